// File: rtl/uart_rx_ctrl_if.sv
// UART receive controller bus: line input, consumer acknowledge, strobes and flags.
// Latency: none; pure wiring bundle.
// Backpressure: none; data_read is the only consumer feedback.
interface uart_rx_ctrl_if;
  logic serial_in;
  logic data_read;
  logic shift_enable;
  logic load_buffer;
  logic data_ready;
  logic framing_error;
  logic overrun_error;

  // Driver/consumer side: feeds the line and acknowledges bytes.
  modport master (
    output serial_in,
    output data_read,
    input  shift_enable,
    input  load_buffer,
    input  data_ready,
    input  framing_error,
    input  overrun_error
  );

  // Controller side: watches the line and produces strobes and flags.
  modport slave (
    input  serial_in,
    input  data_read,
    output shift_enable,
    output load_buffer,
    output data_ready,
    output framing_error,
    output overrun_error
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: times start/data/stop bits and strobes an external shift register.
// Latency: load_buffer fires CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles after the start edge.
// Backpressure: none; an unread byte is overwritten and flagged by overrun_error.
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_ctrl_if.slave bus
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] LOAD  = 3'd4;

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [BW-1:0] bit_cnt;
  logic          prev_in;
  logic          start_edge;
  logic          ready_flag;
  logic          frame_err;
  logic          overrun_flag;

  // Falling edge of the line, only meaningful while idle.
  assign start_edge = prev_in & ~bus.serial_in;

  // Strobes decode directly from state and timer so they can never overlap.
  assign bus.shift_enable  = (state == DATA) && (timer == T_FULL);
  assign bus.load_buffer   = (state == LOAD);
  assign bus.data_ready    = ready_flag;
  assign bus.framing_error = frame_err;
  assign bus.overrun_error = overrun_flag;

  // Frame sequencer: bit timer, bit counter and framing check.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      bit_cnt   <= '0;
      prev_in   <= 1'b1;
      frame_err <= 1'b0;
    end else begin
      prev_in <= bus.serial_in;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state     <= START;
            timer     <= '0;
            frame_err <= 1'b0;
          end
        end
        START: begin
          if (timer == T_HALF) begin
            timer   <= '0;
            bit_cnt <= '0;
            // Line back high at mid start bit means a glitch, not a frame.
            state   <= bus.serial_in ? IDLE : DATA;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DATA: begin
          if (timer == T_FULL) begin
            timer   <= '0;
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == B_LAST) begin
              state <= STOP;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        STOP: begin
          if (timer == T_FULL) begin
            timer <= '0;
            if (bus.serial_in) begin
              state <= LOAD;
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        LOAD: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  // Consumer-facing flags: a read during LOAD keeps the fresh byte valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_flag   <= 1'b0;
      overrun_flag <= 1'b0;
    end else if (state == LOAD) begin
      ready_flag <= 1'b1;
      if (ready_flag && !bus.data_read) begin
        overrun_flag <= 1'b1;
      end else if (bus.data_read) begin
        overrun_flag <= 1'b0;
      end
    end else if (bus.data_read) begin
      ready_flag   <= 1'b0;
      overrun_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed frames with a strobe scoreboard and flag checks.
// Latency: expected strobe cycles are computed from the start-edge cycle of each frame.
// Backpressure: data_read pulses are driven by the stimulus thread.
module tb_uart_rx_ctrl;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic kind;   // 0 = shift_enable, 1 = load_buffer
    int   cyc;
    logic bitv;   // line value expected under a shift strobe
  } ev_t;

  ev_t exp_q[$];

  uart_rx_ctrl_if bus();

  uart_rx_ctrl #(
    .CLKS_PER_BIT(10),
    .DATA_BITS   (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0b required=%0b", name, cyc, act, req);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_shift_enable"},  bus.shift_enable,  1'b0);
    chk({tag, "_load_buffer"},   bus.load_buffer,   1'b0);
    chk({tag, "_data_ready"},    bus.data_ready,    1'b0);
    chk({tag, "_framing_error"}, bus.framing_error, 1'b0);
    chk({tag, "_overrun_error"}, bus.overrun_error, 1'b0);
  endtask

  task automatic pulse_read();
    bus.data_read = 1'b1;
    tick();
    bus.data_read = 1'b0;
  endtask

  // One 10-bit frame; expectations are queued before the line is driven.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic rd_at_load);
    int  c0;
    ev_t e;
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      e.kind = 1'b0; e.cyc = c0 + 15 + 10 * i; e.bitv = d[i];
      exp_q.push_back(e);
    end
    if (stop_bit) begin
      e.kind = 1'b1; e.cyc = c0 + 96; e.bitv = 1'b1;
      exp_q.push_back(e);
    end
    bus.serial_in = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 8; i++) begin
      bus.serial_in = d[i];
      repeat (10) tick();
    end
    bus.serial_in = stop_bit;
    for (int j = 0; j < 10; j++) begin
      bus.data_read = rd_at_load && (cyc == c0 + 96);
      tick();
    end
    bus.data_read = 1'b0;
    bus.serial_in = 1'b1;
  endtask

  // Strobe monitor: every strobe must match the head of the expectation queue.
  initial begin
    ev_t  e;
    logic kind;
    forever begin
      @(negedge clk);
      if (bus.shift_enable || bus.load_buffer) begin
        checks++;
        kind = bus.load_buffer;
        if (bus.shift_enable && bus.load_buffer) begin
          errors++;
          $display("FAIL both_strobes cyc=%0d actual=11 required=one_hot", cyc);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe cyc=%0d actual_kind=%0b required=none", cyc, kind);
        end else begin
          e = exp_q.pop_front();
          if (e.kind !== kind || e.cyc != cyc || (kind == 1'b0 && e.bitv !== bus.serial_in)) begin
            errors++;
            $display("FAIL strobe actual kind=%0b cyc=%0d line=%0b required kind=%0b cyc=%0d line=%0b",
                     kind, cyc, bus.serial_in, e.kind, e.cyc, e.bitv);
          end
        end
      end
    end
  end

  initial begin
    ev_t e;
    rst           = 1'b1;
    bus.serial_in = 1'b1;
    bus.data_read = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (5) tick();

    // Good frame 0x5A: 8 shifts at +15..+85, load at +96.
    send_frame(8'h5A, 1'b1, 1'b0);
    chk("f1_data_ready",    bus.data_ready,    1'b1);
    chk("f1_framing_error", bus.framing_error, 1'b0);
    chk("f1_overrun_error", bus.overrun_error, 1'b0);
    repeat (3) tick();

    // 3-cycle glitch in IDLE: false start, nothing changes.
    bus.serial_in = 1'b0;
    repeat (3) tick();
    bus.serial_in = 1'b1;
    repeat (20) tick();
    chk("glitch_data_ready",    bus.data_ready,    1'b1);
    chk("glitch_framing_error", bus.framing_error, 1'b0);
    chk("glitch_overrun_error", bus.overrun_error, 1'b0);
    pulse_read();
    chk("read1_data_ready", bus.data_ready, 1'b0);

    // Stop bit low: shifts but no load, framing error set.
    send_frame(8'hA5, 1'b0, 1'b0);
    chk("fe_framing_error", bus.framing_error, 1'b1);
    chk("fe_data_ready",    bus.data_ready,    1'b0);
    repeat (5) tick();

    // Next frame clears the framing error, then a back-to-back frame overruns.
    send_frame(8'h3C, 1'b1, 1'b0);
    chk("f3_framing_error", bus.framing_error, 1'b0);
    chk("f3_data_ready",    bus.data_ready,    1'b1);
    chk("f3_overrun_error", bus.overrun_error, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    chk("f4_data_ready",    bus.data_ready,    1'b1);
    chk("f4_overrun_error", bus.overrun_error, 1'b1);
    pulse_read();
    chk("read2_data_ready",    bus.data_ready,    1'b0);
    chk("read2_overrun_error", bus.overrun_error, 1'b0);
    repeat (3) tick();

    // Read coinciding with LOAD of the second frame: byte stays valid, no overrun.
    send_frame(8'h81, 1'b1, 1'b0);
    send_frame(8'h7E, 1'b1, 1'b1);
    chk("rdload_data_ready",    bus.data_ready,    1'b1);
    chk("rdload_overrun_error", bus.overrun_error, 1'b0);
    repeat (3) tick();

    // Reset during data bit 4: only bits 0..3 strobe, all outputs clear.
    begin
      int         c0;
      logic [7:0] d;
      d  = 8'h96;
      c0 = cyc;
      for (int i = 0; i < 4; i++) begin
        e.kind = 1'b0; e.cyc = c0 + 15 + 10 * i; e.bitv = d[i];
        exp_q.push_back(e);
      end
      bus.serial_in = 1'b0;
      repeat (10) tick();
      for (int i = 0; i < 4; i++) begin
        bus.serial_in = d[i];
        repeat (10) tick();
      end
      bus.serial_in = d[4];
      repeat (2) tick();
      rst           = 1'b1;
      bus.serial_in = 1'b1;
      tick();
      chk_all_zero("midrst");
      tick();
      rst = 1'b0;
      repeat (20) tick();
    end

    // Full frame after reset is received normally.
    send_frame(8'h96, 1'b1, 1'b0);
    chk("post_rst_data_ready",    bus.data_ready,    1'b1);
    chk("post_rst_framing_error", bus.framing_error, 1'b0);
    chk("post_rst_overrun_error", bus.overrun_error, 1'b0);
    repeat (5) tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_strobes actual_pending=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
